// File: rtl/ifetch_unit.sv
// Instruction fetch stage: one outstanding imem request, holds the fetched word
// for decode under valid/ready and drives the PC register's load enable.
module ifetch_unit #(
  parameter logic [31:0] RESET_INSTR = 32'h0000_0013,
  parameter int          ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              arst,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_load,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_err,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              fault
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DROP, S_VALID, S_FAULT} state_t;

  state_t            r_state, w_next;
  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_instr_pc;
  logic              w_misalign;

  assign w_misalign = (pc[1:0] != 2'b00);
  assign imem_addr  = pc;
  assign instr      = r_instr;
  assign instr_pc   = r_instr_pc;

  always_ff @(posedge clk) begin
    if (!arst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = S_REQ;
      S_REQ: begin
        if (w_misalign)    w_next = S_FAULT;
        else if (imem_gnt) w_next = flush ? S_DROP : S_WAIT;
      end
      // A squashed response is discarded even if it carries an error.
      S_WAIT: begin
        if (imem_rvalid) begin
          if (flush)         w_next = S_REQ;
          else if (imem_err) w_next = S_FAULT;
          else               w_next = S_VALID;
        end else if (flush) begin
          w_next = S_DROP;
        end
      end
      S_DROP:  if (imem_rvalid) w_next = S_REQ;
      S_VALID: if (flush || instr_ready) w_next = S_REQ;
      S_FAULT: w_next = S_FAULT;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    pc_load     = 1'b0;
    instr_valid = 1'b0;
    fault       = 1'b0;
    case (r_state)
      S_REQ:   imem_req    = !w_misalign;
      S_VALID: begin
        instr_valid = 1'b1;
        pc_load     = instr_ready && !flush;
      end
      S_FAULT: fault       = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst) begin
      r_instr    <= RESET_INSTR;
      r_instr_pc <= '0;
    end else begin
      if (flush && r_state != S_FAULT)
        r_instr <= RESET_INSTR;
      else if (r_state == S_WAIT && imem_rvalid && !imem_err)
        r_instr <= imem_rdata;
      if (r_state == S_REQ && imem_gnt && !w_misalign)
        r_instr_pc <= pc;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: a PC register model, a scripted imem
// responder, and a monitor that checks every accepted instruction.
module tb_ifetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        arst = 1'b0;
  logic [31:0] pc = 32'h0;
  logic        pc_load, flush = 1'b0;
  logic        imem_req, imem_gnt, imem_rvalid, imem_err;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instr, instr_pc;
  logic        instr_valid, instr_ready = 1'b0, fault;

  logic        pc_set = 1'b0;
  logic [31:0] pc_new = 32'h0;
  int          gnt_dly = 0, rv_dly = 1, gnt_budget = 0;
  logic        err_mode = 1'b0;

  int   errors = 0, checks = 0;
  int   load_cnt = 0, acc_cnt = 0;
  exp_t exp_q[$];

  ifetch_unit dut (
    .clk(clk), .arst(arst), .pc(pc), .pc_load(pc_load), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .fault(fault)
  );

  always #5 clk = ~clk;

  // PC register: a redirect overrides the increment.
  always @(posedge clk) begin
    if (pc_set)       pc <= pc_new;
    else if (pc_load) pc <= pc + 32'd4;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h00: return 32'h0050_0093;
      32'h04: return 32'h0010_0113;
      32'h08: return 32'h0020_0193;
      32'h10: return 32'hDEAD_BEEF;
      32'h40: return 32'h0030_0213;
      default: return ~a;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Memory responder: grants after gnt_dly request cycles, answers rv_dly cycles later.
  initial begin : responder
    logic        pending;
    int          g_cnt, rv_cnt;
    logic [31:0] pend_data;
    pending = 1'b0; g_cnt = 0; rv_cnt = 0; pend_data = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_err = 1'b0; imem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_err = 1'b0; imem_rdata = '0;
      if (pending) begin
        if (rv_cnt >= rv_dly) begin
          imem_rvalid = 1'b1; imem_rdata = pend_data; imem_err = err_mode;
          pending = 1'b0;
        end else rv_cnt++;
      end else if (imem_req && gnt_budget > 0) begin
        if (g_cnt == gnt_dly) begin
          imem_gnt = 1'b1; g_cnt = 0; gnt_budget--;
          pending = 1'b1; rv_cnt = 1; pend_data = mem_word(imem_addr);
        end else g_cnt++;
      end
    end
  end

  // Monitor: every accepted instruction is popped from the scoreboard.
  always @(negedge clk) begin
    if (pc_load) load_cnt++;
    if (instr_valid && instr_ready && !flush) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_empty: got instr %h pc %h expected no delivery", instr, instr_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_instr", instr, e.instr);
        chk("sb_instr_pc", instr_pc, e.pc);
        chk("sb_pc_load", {31'b0, pc_load}, 32'd1);
      end
      acc_cnt++;
    end else if (pc_load) begin
      chk("pc_load_stray", {31'b0, pc_load}, 32'd0);
    end
  end

  task automatic wait_acc(input int target, output int dead);
    int n;
    dead = 0;
    n = 0;
    while (acc_cnt < target && n < 60) begin
      if (instr_valid && instr == 32'hDEAD_BEEF) dead++;
      tick(); n++;
    end
    chk("acc_timeout", acc_cnt, target);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dead, req_cycles, n;
    logic seen_req;
    // Reset state
    tick(); tick();
    chk("rst_req", {31'b0, imem_req}, 0);
    chk("rst_pc_load", {31'b0, pc_load}, 0);
    chk("rst_valid", {31'b0, instr_valid}, 0);
    chk("rst_fault", {31'b0, fault}, 0);
    chk("rst_instr", instr, NOP);
    chk("rst_instr_pc", instr_pc, 0);

    // Best case: valid and pc_load on the third cycle, then request at pc+4
    exp_q.push_back('{32'h0050_0093, 32'h0});
    gnt_budget = 1; rv_dly = 1; instr_ready = 1'b1; arst = 1'b1;
    tick(); tick();
    chk("t1_not_yet_valid", {31'b0, instr_valid}, 0);
    tick();
    chk("t1_valid_c3", {31'b0, instr_valid}, 1);
    chk("t1_pc_load_c3", {31'b0, pc_load}, 1);
    tick();
    chk("t1_next_req", {31'b0, imem_req}, 1);
    chk("t1_next_addr", imem_addr, 32'h4);
    chk("t1_load_cnt", load_cnt, 1);

    // Decode stall: output held, no pc_load, no new request
    instr_ready = 1'b0;
    exp_q.push_back('{32'h0010_0113, 32'h4});
    gnt_budget = 1;
    n = 0;
    while (!instr_valid && n < 20) begin tick(); n++; end
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold", {instr_valid, pc_load, imem_req, instr[28:0]}, {3'b100, 29'h0010_0113});
      chk("t2_hold_pc", instr_pc, 32'h4);
      tick();
    end
    instr_ready = 1'b1;
    tick(); tick();
    chk("t2_load_cnt", load_cnt, 2);

    // Slow bus: gnt after 3 extra request cycles, rvalid in the 4th wait cycle
    gnt_dly = 3; rv_dly = 4; gnt_budget = 1;
    exp_q.push_back('{32'h0020_0193, 32'h8});
    req_cycles = 0; n = 0;
    while (!instr_valid && n < 30) begin
      if (imem_req) begin
        req_cycles++;
        chk("t3_addr_const", imem_addr, 32'h8);
      end
      chk("t3_no_pc_load", {31'b0, pc_load}, 0);
      tick(); n++;
    end
    chk("t3_req_cycles", req_cycles, 4);
    wait_acc(3, dead);
    gnt_dly = 0;

    // Flush in WAIT: 0xDEADBEEF is dropped, refetch from redirected pc
    pc_set = 1'b1; pc_new = 32'h10;
    tick();
    pc_set = 1'b0; rv_dly = 3; gnt_budget = 1;
    tick();
    flush = 1'b1; pc_set = 1'b1; pc_new = 32'h40; gnt_budget = 1;
    exp_q.push_back('{32'h0030_0213, 32'h40});
    tick();
    flush = 1'b0; pc_set = 1'b0;
    chk("t4_instr_nop", instr, NOP);
    chk("t4_valid_low", {31'b0, instr_valid}, 0);
    seen_req = 1'b0; n = 0; dead = 0;
    while (acc_cnt < 4 && n < 60) begin
      if (imem_req && !seen_req) begin
        seen_req = 1'b1;
        chk("t4_redirect_addr", imem_addr, 32'h40);
      end
      if (instr_valid && instr == 32'hDEAD_BEEF) dead++;
      tick(); n++;
    end
    chk("t4_acc", acc_cnt, 4);
    chk("t4_dead_seen", dead, 0);

    // Misaligned pc traps without a request; fault is sticky through flush
    pc_set = 1'b1; pc_new = 32'h6;
    tick();
    pc_set = 1'b0;
    chk("t5_misalign_req", {31'b0, imem_req}, 0);
    tick();
    chk("t5_fault", {31'b0, fault}, 1);
    flush = 1'b1; tick(); flush = 1'b0; tick();
    chk("t5_sticky", {29'b0, fault, imem_req, instr_valid}, 32'b100);
    arst = 1'b0; tick();
    chk("t5_rst_clear", {31'b0, fault}, 0);

    // Bus error response
    pc_set = 1'b1; pc_new = 32'h8;
    tick();
    pc_set = 1'b0; err_mode = 1'b1; rv_dly = 1; gnt_budget = 1; arst = 1'b1;
    n = 0;
    while (!fault && n < 20) begin tick(); n++; end
    chk("t5_err_fault", {31'b0, fault}, 1);
    chk("t5_err_instr", instr, NOP);
    chk("t5_err_valid", {31'b0, instr_valid}, 0);
    err_mode = 1'b0; arst = 1'b0; tick();
    chk("t5_err_clear", {31'b0, fault}, 0);

    // Reset mid-WAIT: late response ignored, fetch restarts
    pc_set = 1'b1; pc_new = 32'h10;
    tick();
    pc_set = 1'b0; rv_dly = 3; gnt_budget = 1; arst = 1'b1;
    tick(); tick();
    chk("t6_in_wait", {30'b0, imem_req, instr_valid}, 0);
    arst = 1'b0; pc_set = 1'b1; pc_new = 32'h40;
    tick();
    pc_set = 1'b0;
    chk("t6_rst_outs", {28'b0, imem_req, pc_load, instr_valid, fault}, 0);
    chk("t6_rst_instr", instr, NOP);
    chk("t6_rst_instr_pc", instr_pc, 0);
    exp_q.push_back('{32'h0030_0213, 32'h40});
    gnt_budget = 1; arst = 1'b1;
    wait_acc(5, dead);
    chk("t6_dead_seen", dead, 0);
    chk("sb_drained", exp_q.size(), 0);
    chk("load_total", load_cnt, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
